// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types for the round-robin register arbiter: state encoding and the
// round-robin winner search used by rr_reg_arbiter.
package rr_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GRANT = 2'b01;
  localparam logic [1:0] S_LOCK  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_GRANT = S_GRANT,
    ST_LOCK  = S_LOCK
  } rr_state_e;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_win_t;

  // First set request at or after ptr, wrapping at n; ptr must be below n.
  function automatic rr_win_t rr_winner(input logic [RR_MAX_N-1:0] req,
                                        input int unsigned ptr,
                                        input int unsigned n);
    rr_win_t     r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!r.found && req[idx[RR_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = idx[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_dff_bank.sv
// W-bit shared register with load enable and synchronous active-low reset.
module dff_bank #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters with lock.
// Define RR_ARB_TIMEOUT_EN to force lock release after LOCK_MAX LOCK cycles.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int W        = 8,
  parameter  int LOCK_MAX = 4,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           sync_reset_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [IW-1:0]  gnt_id,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic           busy,
  output logic           timeout
);

  rr_state_e     r_state;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_id;
  logic          r_q_valid;

  logic                w_active;
  logic                w_keep;
  logic                w_force;
  logic                w_hold;
  logic [IW-1:0]       w_nptr;
  logic [IW-1:0]       w_arb_ptr;
  logic [RR_MAX_N-1:0] w_req_ext;
  rr_win_t             w_win;
  logic                w_load;
  logic [IW-1:0]       w_sel;
  logic [N-1:0]        w_onehot;
  logic [W-1:0]        w_d;
  logic [W-1:0]        w_q;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
`endif

  assign w_req_ext = RR_MAX_N'(req);

  always_comb begin
    w_active  = (r_state != ST_IDLE);
    w_keep    = w_active && req[r_gnt_id] && lock[r_gnt_id];
`ifdef RR_ARB_TIMEOUT_EN
    w_force   = w_keep && (r_state == ST_LOCK) && (r_cnt == CW'(LOCK_MAX - 1));
`else
    w_force   = 1'b0;
`endif
    w_hold    = w_keep && !w_force;
    w_nptr    = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;
    // On release, arbitrate this same edge from the advanced pointer.
    w_arb_ptr = w_active ? w_nptr : r_ptr;
    w_win     = rr_winner(w_req_ext, 32'(w_arb_ptr), N);
    w_load    = w_hold || w_win.found;
    w_sel     = w_hold ? r_gnt_id : IW'(w_win.idx);
    w_onehot  = '0;
    w_onehot[w_sel] = 1'b1;
    w_d       = wdata[int'(w_sel)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_load;
      if (w_active && !w_hold) r_ptr <= w_nptr;
      if (w_hold) begin
        r_state <= ST_LOCK;
      end else if (w_win.found) begin
        r_state  <= ST_GRANT;
        r_gnt    <= w_onehot;
        r_gnt_id <= w_sel;
      end else begin
        r_state  <= ST_IDLE;
        r_gnt    <= '0;
        r_gnt_id <= '0;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // r_cnt counts LOCK cycles already completed in the current hold.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (!w_hold)                    r_cnt <= '0;
      else if (r_state == ST_LOCK)    r_cnt <= r_cnt + 1'b1;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  dff_bank #(.W(W)) u_bank (
    .i_clk   (clk),
    .i_rst_n (sync_reset_n),
    .i_en    (w_load),
    .i_d     (w_d),
    .o_q     (w_q)
  );

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign q       = w_q;
  assign q_valid = r_q_valid;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter (N=4, W=8, LOCK_MAX=4).
module tb_rr_reg_arbiter;

  logic        clk = 1'b0;
  logic        sync_reset_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  q;
  logic        q_valid;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  rr_reg_arbiter #(.N(4), .W(8), .LOCK_MAX(4)) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .req          (req),
    .lock         (lock),
    .wdata        (wdata),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .q            (q),
    .q_valid      (q_valid),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                         input logic [7:0] e_q, input logic e_qv, input logic e_busy);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_id));
    chk({tag, ".q"}, 32'(q), 32'(e_q));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(e_qv));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".timeout"}, 32'(timeout), 32'(0));
  endtask

  task automatic set_wd(input int i, input logic [7:0] v);
    wdata[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    sync_reset_n = 1'b0;
    tick();
    sync_reset_n = 1'b1;
  endtask

  initial begin
    sync_reset_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = 32'h44332211;
    tick();
    tick();
    chk_out("reset", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("reset.ptr", 32'(dut.r_ptr), 32'd0);
    sync_reset_n = 1'b1;

    // Single requester, pulsed for one edge
    req = 4'b0100;
    set_wd(2, 8'h5A);
    tick();
    chk_out("single.grant", 4'b0100, 2'd2, 8'h5A, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    chk_out("single.idle", 4'b0000, 2'd0, 8'h5A, 1'b0, 1'b0);
    chk("single.ptr", 32'(dut.r_ptr), 32'd3);

    // Fairness from ptr=0 with all requesting
    do_reset();
    wdata = 32'h44332211;
    req   = 4'b1111;
    tick(); chk_out("fair0", 4'b0001, 2'd0, 8'h11, 1'b1, 1'b1);
    tick(); chk_out("fair1", 4'b0010, 2'd1, 8'h22, 1'b1, 1'b1);
    tick(); chk_out("fair2", 4'b0100, 2'd2, 8'h33, 1'b1, 1'b1);
    tick(); chk_out("fair3", 4'b1000, 2'd3, 8'h44, 1'b1, 1'b1);
    tick(); chk_out("fair4", 4'b0001, 2'd0, 8'h11, 1'b1, 1'b1);
    req = 4'b0000;
    tick(); chk_out("fair.idle", 4'b0000, 2'd0, 8'h11, 1'b0, 1'b0);
    chk("fair.ptr", 32'(dut.r_ptr), 32'd1);

    // Lock held by requester 1 for three loads
    req  = 4'b0010;
    lock = 4'b0010;
    set_wd(1, 8'h01);
    tick(); chk_out("lock1", 4'b0010, 2'd1, 8'h01, 1'b1, 1'b1);
    set_wd(1, 8'h02);
    tick(); chk_out("lock2", 4'b0010, 2'd1, 8'h02, 1'b1, 1'b1);
    set_wd(1, 8'h03);
    tick(); chk_out("lock3", 4'b0010, 2'd1, 8'h03, 1'b1, 1'b1);
    req  = 4'b0000;
    lock = 4'b0000;
    set_wd(1, 8'hEE);
    tick(); chk_out("lock.release", 4'b0000, 2'd0, 8'h03, 1'b0, 1'b0);
    chk("lock.ptr", 32'(dut.r_ptr), 32'd2);

    // Lock timeout: requester 0 locks while requester 1 waits
    do_reset();
    set_wd(0, 8'hA0);
    set_wd(1, 8'hB1);
    req  = 4'b0011;
    lock = 4'b0001;
    tick(); chk_out("to.grant", 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_out("to.lock", 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b1);
    end
    tick();
`ifdef RR_ARB_TIMEOUT_EN
    chk("to.force.gnt", 32'(gnt), 32'b0010);
    chk("to.force.q", 32'(q), 32'hB1);
    chk("to.force.pulse", 32'(timeout), 32'd1);
    tick();
    chk("to.after.gnt", 32'(gnt), 32'b0001);
    chk("to.after.pulse", 32'(timeout), 32'd0);
`else
    chk_out("to.held5", 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b1);
    tick();
    chk_out("to.held6", 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b1);
`endif

    // Reset while in LOCK
    do_reset();
    set_wd(0, 8'hC0);
    req  = 4'b0001;
    lock = 4'b0001;
    tick();
    tick(); chk_out("rstlock.pre", 4'b0001, 2'd0, 8'hC0, 1'b1, 1'b1);
    sync_reset_n = 1'b0;
    tick(); chk_out("rstlock.post", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("rstlock.ptr", 32'(dut.r_ptr), 32'd0);
    sync_reset_n = 1'b1;
    lock = 4'b0000;
    req  = 4'b1000;
    set_wd(3, 8'hD3);
    tick(); chk_out("rstlock.req3", 4'b1000, 2'd3, 8'hD3, 1'b1, 1'b1);

    // Wrap-around from ptr=3 with requesters 3 and 0
    req = 4'b0000;
    tick();
    req = 4'b0100;
    set_wd(2, 8'h62);
    tick();
    req = 4'b0000;
    tick();
    chk("wrap.ptr", 32'(dut.r_ptr), 32'd3);
    set_wd(0, 8'h70);
    set_wd(3, 8'h73);
    req = 4'b1001;
    tick(); chk_out("wrap3a", 4'b1000, 2'd3, 8'h73, 1'b1, 1'b1);
    tick(); chk_out("wrap0",  4'b0001, 2'd0, 8'h70, 1'b1, 1'b1);
    tick(); chk_out("wrap3b", 4'b1000, 2'd3, 8'h73, 1'b1, 1'b1);
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter and sequencer that shares one W-bit synchronously-reset register among N requesters. Each cycle it grants at most one requester and loads that requester's data into the shared register. A granted requester may lock the register for consecutive loads. The block is the access controller in front of the team's flip-flop register banks.

## Interface
- N, default 4: number of requesters (≥1)
- W, default 8: width of the shared register
- LOCK_MAX, default 4: maximum consecutive LOCK-state cycles (used only with timeout compiled in)
- clk  in  1  rising-edge clock
- sync_reset_n  in  1  reset, synchronous, active-low; the only clock and reset in the block
- req  in  N  request per requester, level
- lock  in  N  per-requester request to keep the grant after the first load
- wdata  in  N*W  requester i data at [i*W +: W]
- gnt  out  N  registered one-hot grant; all-zero when idle
- gnt_id  out  clog2(N) (min 1)  index of current grantee; 0 when idle
- q  out  W  shared register contents
- q_valid  out  1  high in each cycle after an edge that loaded q
- busy  out  1  high in GRANT or LOCK
- timeout  out  1  one-cycle pulse on forced lock release; constant 0 without timeout

## Operation
- States:
  - IDLE: no grant.
  - GRANT: first load cycle.
  - LOCK: held grant.
- Round-robin pointer ptr, in 0..N-1. Winner = first i with req[i]=1, searching ptr, ptr+1, …, wrapping N-1→0.
- IDLE, any req set:
  - Edge: state←GRANT, gnt←onehot(winner), gnt_id←winner, q←wdata[winner], q_valid←1.
- IDLE, no req: outputs hold q; gnt=0, q_valid=0.
- GRANT or LOCK with grantee g, lock[g]&req[g]=1 and no timeout:
  - state←LOCK, q←wdata[g], q_valid←1, gnt held.
- GRANT or LOCK, release (req[g]=0, lock[g]=0, or timeout):
  - ptr←(g+1) mod N.
  - Arbitration runs in the same edge using the new ptr. If a winner exists, go to GRANT with it (no bubble). Otherwise go to IDLE with gnt=0, q_valid=0.
- A requester that drops req while granted is released at that edge. Its wdata is not loaded.
- N=1: ptr stays 0; requester 0 wins every arbitration.
- q changes only on load edges; it is never cleared except by reset.

## Timing
- Request-to-grant latency is 1 edge. req sampled high at edge k gives gnt, q and q_valid valid in cycle k+1.
- Back-to-back grants to different requesters have no idle cycle.
- Every output is registered; there is no combinational path from inputs to outputs.
- Reset: sync_reset_n low at an edge forces, after that edge, state=IDLE, ptr=0, gnt=0, gnt_id=0, q=0, q_valid=0, busy=0, timeout=0. This applies mid-GRANT or mid-LOCK; the lock is dropped with no timeout pulse.
- Simultaneous requests are resolved only by ptr order. Lower index has no fixed priority.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - Lock counter increments in each LOCK cycle.
  - When LOCK_MAX LOCK cycles have completed, the next edge forces release even if lock[g]&req[g]=1.
  - timeout pulses 1 for one cycle, and ptr advances past g.
  - The counter clears on every entry to GRANT.
- RR_ARB_TIMEOUT_EN undefined:
  - No counter. LOCK is held indefinitely while lock[g]&req[g]=1.
  - timeout is tied to 0 and LOCK_MAX is ignored.

## Structure
- Package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT, LOCK) typedef
  - the state encoding constants
  - a function returning the round-robin winner index and found flag from req and ptr
- Sub-module dff_bank: W-bit register with load enable and synchronous active-low reset, holding q. The arbiter drives its enable and data mux.

## Test plan
- Single requester, N=4, W=8, reset then req=0100, wdata[2]=0x5A, lock=0:
  - Cycle after the edge: gnt=0100, gnt_id=2, q=0x5A, q_valid=1.
  - Next cycle: gnt=0, ptr=3.
- Fairness, req=1111 held, lock=0, ptr=0: grants 0,1,2,3,0 on consecutive cycles with no gaps; q tracks each wdata slice.
- Lock, req=0010 and lock=0010 for 3 cycles, wdata[1]=0x01,0x02,0x03:
  - busy=1 and gnt=0010 throughout.
  - q=0x01,0x02,0x03 in successive cycles.
  - Release when lock drops.
- Timeout (RR_ARB_TIMEOUT_EN, LOCK_MAX=4), req=0011 and lock=0001 held:
  - Requester 0 holds the grant for 1 GRANT + 4 LOCK cycles.
  - timeout=1 for one cycle and requester 1 is granted in that same cycle.
  - Without the macro, requester 0 keeps the grant indefinitely.
- Reset mid-LOCK: sync_reset_n=0 for one edge during LOCK → all outputs 0 and ptr=0 next cycle. req=1000 then grants 3 one edge after reset is released.
- Wrap-around: ptr=3, req=1001 → requester 3 wins, then requester 0, then requester 3.
